// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int DEFAULT_CLK_PER_BIT = 868;
  localparam int UART_DATA_W         = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational winner search starting at ptr,
// plus the pointer register that advances past each granted requester.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  index,
  output logic             any
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;

  // First valid requester scanning ptr, ptr+1, ... modulo N_REQ
  always_comb begin
    any   = 1'b0;
    index = '0;
    grant = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!any && valid[cand]) begin
        any   = 1'b1;
        index = cand;
      end
    end
    if (enable && any) grant[index] = 1'b1;
  end

  // Pointer moves to the requester after the winner on every grant
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (enable && any) begin
      ptr <= (int'(index) == N_REQ - 1) ? '0 : index + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX line between N_REQ byte producers, 8N1 framing.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1 framing).
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ*UART_DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]               req_ready,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] grant_id,
  output logic                           busy,
  output logic                           UART_TX
);

  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BAUD_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);

  uart_tx_state_t         state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shreg;
  logic [UART_DATA_W-1:0] req_bytes [N_REQ];
  logic [ID_W-1:0]        win_idx;
  logic                   win_any;
  logic                   arb_en;
  logic                   bit_end;
`ifdef UART_TX_PARITY_EN
  logic                   parity_bit;
`endif

  // Arbitration only in IDLE; reset also masks req_ready
  assign arb_en  = (state == IDLE) && !RST;
  assign busy    = (state != IDLE);
  assign bit_end = (baud_cnt == BAUD_LAST);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk    (CLK),
    .rst    (RST),
    .valid  (req_valid),
    .enable (arb_en),
    .grant  (req_ready),
    .index  (win_idx),
    .any    (win_any)
  );

  // Unpack the flat byte bus into one byte per requester
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = req_data[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  // Byte datapath: load on grant, shift right after each data bit
  always_ff @(posedge CLK) begin
    if (state == IDLE && win_any) begin
      shreg <= req_bytes[win_idx];
`ifdef UART_TX_PARITY_EN
      parity_bit <= ^req_bytes[win_idx];
`endif
    end else if (state == DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

  // Frame FSM with baud and bit counters; UART_TX comes straight from a flop
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      grant_id <= '0;
      UART_TX  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (win_any) begin
            state    <= START;
            grant_id <= win_idx;
            UART_TX  <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            UART_TX  <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= PARITY;
              UART_TX <= parity_bit;
`else
              state   <= STOP;
              UART_TX <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              UART_TX <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state    <= STOP;
            baud_cnt <= '0;
            UART_TX  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_end) begin
            state    <= IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          UART_TX  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with N_REQ=2, CLK_PER_BIT=4.
// Honours UART_TX_PARITY_EN when defined for the build.
module tb_uart_tx_arbiter;

  localparam int N   = 2;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS    = 11;
  localparam int FRAME_HC = 44;
  localparam int SPACE_HC = 45;
`else
  localparam int NBITS    = 10;
  localparam int FRAME_HC = 40;
  localparam int SPACE_HC = 41;
`endif
  localparam int FRAME = NBITS * CPB;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*8-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic [0:0]     grant_id;
  logic           busy;
  logic           UART_TX;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(.N_REQ(N), .CLK_PER_BIT(CPB)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .busy      (busy),
    .UART_TX   (UART_TX)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Frame-level reference model: a frame is a list of line bits, each CPB cycles
  int               m_left = 0;
  int               m_ptr  = 0;
  int               m_gid  = 0;
  logic [NBITS-1:0] m_bits = '0;
  bit               chk_en = 1'b0;
  int               cyc_n  = 0;
  int               grant_q[$];
  int               start_q[$];
  int               busy_len_q[$];
  int               busy_run  = 0;
  logic             prev_busy = 1'b0;

  always @(posedge CLK) cyc_n++;

  always @(negedge CLK) begin
    int           w;
    logic [N-1:0] er;
    logic         et;
    logic [7:0]   d;
    if (chk_en) begin
      if (RST) begin
        m_left = 0; m_ptr = 0; m_gid = 0;
        busy_run = 0; prev_busy = 1'b0;
        check("rst_tx",    32'(UART_TX),   32'd1);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_gid",   32'(grant_id),  32'd0);
      end else begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        er = '0;
        if (m_left == 0 && w >= 0) er[w] = 1'b1;
        et = (m_left > 0) ? m_bits[(FRAME - m_left) / CPB] : 1'b1;
        check("line",  32'(UART_TX),   32'(et));
        check("busy",  32'(busy),      32'(m_left > 0));
        check("ready", 32'(req_ready), 32'(er));
        check("gid",   32'(grant_id),  32'(m_gid));
        // event logs for the directed checks
        for (int k = 0; k < N; k++) if (req_ready[k]) grant_q.push_back(k);
        if (!prev_busy && busy && !UART_TX) start_q.push_back(cyc_n);
        if (busy) busy_run++;
        else if (prev_busy) begin busy_len_q.push_back(busy_run); busy_run = 0; end
        prev_busy = busy;
        // advance model to the next cycle
        if (m_left > 0) begin
          m_left--;
        end else if (w >= 0) begin
          d = req_data[w*8 +: 8];
`ifdef UART_TX_PARITY_EN
          m_bits = {1'b1, ^d, d, 1'b0};
`else
          m_bits = {1'b1, d, 1'b0};
`endif
          m_left = FRAME;
          m_gid  = w;
          m_ptr  = (w + 1) % N;
        end
      end
    end
  end

  task automatic wait_idle(input int lim);
    int i;
    i = 0;
    while (busy && i < lim) begin @(negedge CLK); i++; end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int i;
`ifdef UART_TX_PARITY_EN
    logic [10:0] pat;
    pat = 11'b10101001010;
`else
    logic [9:0] pat;
    pat = 10'b1101001010;
`endif
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    chk_en = 1'b1;
    @(posedge CLK); #1 RST = 1'b0;

    // idle after reset
    repeat (50) @(posedge CLK);
    #1;
    check("idle_tx",    32'(UART_TX),   32'd1);
    check("idle_busy",  32'(busy),      32'd0);
    check("idle_ready", 32'(req_ready), 32'd0);
    check("idle_gid",   32'(grant_id),  32'd0);

    // round-robin fairness with both requesters held valid
    grant_q.delete(); start_q.delete();
    req_data  = {8'h22, 8'h11};
    req_valid = 2'b11;
    i = 0;
    while (grant_q.size() < 4 && i < 400) begin @(negedge CLK); i++; end
    @(posedge CLK); #1 req_valid = 2'b00;
    check("rr_count", 32'(grant_q.size()), 32'd4);
    if (grant_q.size() >= 4) begin
      check("rr_g0", 32'(grant_q[0]), 32'd0);
      check("rr_g1", 32'(grant_q[1]), 32'd1);
      check("rr_g2", 32'(grant_q[2]), 32'd0);
      check("rr_g3", 32'(grant_q[3]), 32'd1);
    end
    wait_idle(100);
    check("rr_starts", 32'(start_q.size()), 32'd4);
    if (start_q.size() >= 4)
      for (int k = 1; k < 4; k++)
        check("rr_spacing", 32'(start_q[k] - start_q[k-1]), 32'(SPACE_HC));

    // single byte A5 from requester 0
    @(posedge CLK); #1;
    busy_len_q.delete();
    req_data  = 16'h00A5;
    req_valid = 2'b01;
    @(negedge CLK);
    check("single_ready", 32'(req_ready), 32'd1);
    @(posedge CLK); #1 req_valid = 2'b00;
    check("single_gid", 32'(grant_id), 32'd0);
    for (int b = 0; b < NBITS; b++) begin
      repeat (2) @(negedge CLK);
      check("single_bit", 32'(UART_TX), 32'(pat[b]));
      repeat (2) @(negedge CLK);
    end
    wait_idle(20);
    repeat (2) @(negedge CLK);
    check("single_busy_n", 32'(busy_len_q.size()), 32'd1);
    if (busy_len_q.size() >= 1) check("single_busy_len", 32'(busy_len_q[0]), 32'(FRAME_HC));

    // pointer at 1, only requester 0 valid: it wins anyway
    @(posedge CLK); #1;
    req_data  = 16'h003C;
    req_valid = 2'b01;
    @(negedge CLK);
    check("skip_ready", 32'(req_ready), 32'd1);
    @(posedge CLK); #1 req_valid = 2'b00;
    check("skip_gid", 32'(grant_id), 32'd0);
    wait_idle(100);

    // pointer still 1: both valid grants requester 1; then reset mid-frame
    @(posedge CLK); #1;
    req_data  = 16'h005A;
    req_valid = 2'b11;
    @(negedge CLK);
    check("ptr_kept_ready", 32'(req_ready), 32'd2);
    @(posedge CLK); #1;
    check("ptr_kept_gid", 32'(grant_id), 32'd1);
    repeat (17) @(posedge CLK);
    #2;
    check("pre_rst_tx", 32'(UART_TX), 32'd0);
    RST = 1'b1;
    #1;
    check("async_rst_tx",   32'(UART_TX), 32'd1);
    check("async_rst_busy", 32'(busy),    32'd0);
    @(posedge CLK); @(posedge CLK); #1 RST = 1'b0;
    busy_len_q.delete();
    @(negedge CLK);
    check("rearb_ready", 32'(req_ready), 32'd1);
    @(posedge CLK); #1 req_valid = 2'b00;
    wait_idle(100);
    repeat (2) @(negedge CLK);
    check("rearb_busy_n", 32'(busy_len_q.size()), 32'd1);
    if (busy_len_q.size() >= 1) check("rearb_busy_len", 32'(busy_len_q[0]), 32'(FRAME_HC));

`ifdef UART_TX_PARITY_EN
    // parity of 8'h07 is 1, sent after the data bits
    @(posedge CLK); #1;
    busy_len_q.delete();
    req_data  = 16'h0700;
    req_valid = 2'b10;
    @(negedge CLK);
    check("par_ready", 32'(req_ready), 32'd2);
    @(posedge CLK); #1 req_valid = 2'b00;
    repeat (38) @(negedge CLK);
    check("par_bit", 32'(UART_TX), 32'd1);
    wait_idle(20);
    repeat (2) @(negedge CLK);
    if (busy_len_q.size() >= 1) check("par_busy_len", 32'(busy_len_q[0]), 32'd44);
    else check("par_busy_n", 32'(busy_len_q.size()), 32'd1);
`endif

    repeat (5) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit line between N_REQ byte-producing requesters. A round-robin arbiter grants one requester per frame. A built-in baud counter and frame FSM serialise the granted byte as 8N1: start bit, 8 data bits LSB-first, one stop bit. It sits between on-chip debug/result producers and the board-level UART_TX pin, replacing fixed-pattern senders.

Parameters:
N_REQ, 2, number of requesters (2..8)
CLK_PER_BIT, 868, CLK cycles per UART bit (100 MHz / 115200 baud); minimum 2

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous, active-high reset
req_valid  input  N_REQ  per-requester byte-available flag
req_data  input  N_REQ*8  per-requester byte; requester i occupies bits [8i+7:8i]
req_ready  output  N_REQ  one-hot acceptance pulse; byte i is taken when req_valid[i] & req_ready[i]
grant_id  output  $clog2(N_REQ) (min 1)  index of last granted requester
busy  output  1  high from the cycle after acceptance until the frame ends
UART_TX  output  1  serial line, idle high

Behaviour:
- Interface is fixed: one clock, CLK; RST is asynchronous and active-high.
- Reset values: UART_TX=1, req_ready=0, busy=0, grant_id=0, rr_ptr=0, state=IDLE, bit/baud counters=0. Asserting RST mid-frame forces UART_TX high immediately. No partial frame resumes.
- FSM states: IDLE, START, DATA, STOP (PARITY when the optional feature is enabled).
- IDLE, arbitration:
  - If any req_valid is set, the winner is the first set index scanning rr_ptr, rr_ptr+1, … modulo N_REQ.
  - In that same cycle, req_ready[winner]=1 (combinational from valid and state), the byte is latched into the shift register, grant_id<=winner, rr_ptr<=(winner+1) mod N_REQ, and the next state is START.
  - With no valid, stay in IDLE; rr_ptr is unchanged.
- req_ready is never asserted outside IDLE. At most one bit is set.
- Requesters may hold valid across frames. A dropped valid before grant is legal; no byte is lost or duplicated.
- START: UART_TX=0 for exactly CLK_PER_BIT cycles.
- DATA: 8 bits, each held CLK_PER_BIT cycles, LSB first. The bit counter runs 0..7.
- STOP: UART_TX=1 for CLK_PER_BIT cycles, then IDLE.
- Frame timing:
  - Acceptance-to-line is one cycle: the start bit begins the cycle after req_ready.
  - Frame length is 10*CLK_PER_BIT cycles.
  - Minimum spacing between consecutive start-bit edges is 10*CLK_PER_BIT+1 (one IDLE arbitration cycle).
- Baud counter counts 0..CLK_PER_BIT-1 and wraps. It resets to 0 on every state entry.
- busy = (state != IDLE).
- UART_TX is registered: glitch-free, driven from a flop.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles. Frame length becomes 11*CLK_PER_BIT.
- Undefined: plain 8N1 as above. No PARITY state or parity logic exists.

Decomposition:
- Package uart_pkg:
  - state enum uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}
  - localparam DEFAULT_CLK_PER_BIT=868
  - localparam UART_DATA_W=8
- Sub-module rr_arbiter, purely combinational plus pointer register. It takes valid[N_REQ] and enable, and returns a one-hot grant and an encoded index. The FSM and baud timing stay in uart_tx_arbiter.

Test Plan:
All scenarios use CLK_PER_BIT=4.
- Reset and idle: hold RST, release, no valid for 50 cycles -> UART_TX=1, busy=0, req_ready=0 throughout.
- Single byte: req_valid=2'b01, req_data[7:0]=8'hA5 -> req_ready[0] pulses 1 cycle, grant_id=0. From the next cycle, UART_TX shows 0,1,0,1,0,0,1,0,1,1, each 4 cycles. busy is high exactly 40 cycles.
- Round-robin fairness: both valid held continuously, bytes 8'h11 (req0) and 8'h22 (req1) -> grant order 0,1,0,1. Start-bit edges are 41 cycles apart.
- Pointer skip: rr_ptr=1, only req0 valid -> req0 granted, rr_ptr becomes 1.
- Reset mid-frame: assert RST 17 cycles into a frame -> UART_TX=1 asynchronously. After release, the FSM is in IDLE and re-arbitrates the still-valid requester with a fresh full frame.
- With UART_TX_PARITY_EN: send 8'h07 -> parity bit 1 after the data bits. Frame is 44 cycles; busy high for 44 cycles.
